// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  // Exception vector byte addresses.
  localparam logic [31:0] VEC_D = 32'd253;
  localparam logic [31:0] VEC_E = 32'd254;
  localparam logic [31:0] VEC_F = 32'd255;

  // Illegal size or an access not aligned to its own size.
  function automatic logic size_err(input size_t size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      SZ_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
module mem_lane
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  size_t       size_i,
  input  logic        sign_ext_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word_i[{offset_i, 3'b000} +: 8];
  assign half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // Select the addressed lane and extend it to 32 bits.
  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      SZ_HALF: load_o = {{16{sign_ext_i & half_v[15]}}, half_v};
      default: load_o = word_i;
    endcase
  end

  // Replace the addressed lane with the low bits of the store data.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
        else             merge_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: merge_o = wdata_i;
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one load/store request onto a word-wide synchronous memory.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] VEC_BASE    = 32'd253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        vec_hit,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] CntLast = 2'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  size_t       size_q, size_d;
  logic        wr_q, wr_d;
  logic        sx_q, sx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        vec_q, vec_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] lane_load, lane_merge;

  mem_lane u_lane (
    .word_i     (mem_rdata),
    .wdata_i    (wdata_q),
    .offset_i   (off_q),
    .size_i     (size_q),
    .sign_ext_i (sx_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      wr_q        <= 1'b0;
      sx_q        <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      vec_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      wr_q        <= wr_d;
      sx_q        <= sx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      vec_q       <= vec_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: accept in IDLE, wait out read latency, capture, write, complete.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    wr_d        = wr_q;
    sx_d        = sx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    vec_d       = vec_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          off_d      = addr[1:0];
          size_d     = size_t'(size);
          wr_d       = wr;
          sx_d       = sign_ext;
          wdata_d    = wdata;
          err_d      = size_err(size_t'(size), addr[1:0]);
          vec_d      = (addr >= VEC_BASE) && (addr <= VEC_F);
          mem_addr_d = {addr[31:2], 2'b00};
          cnt_d      = '0;
          if (err_d) begin
            state_d = DONE;
          end else if (wr && size_t'(size) == SZ_WORD) begin
            state_d     = WR;
            mem_wdata_d = wdata;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == CntLast) state_d = CAP;
        else                  cnt_d   = cnt_q + 2'd1;
      end
      CAP: begin
        if (wr_q) begin
          mem_wdata_d = lane_merge;
          state_d     = WR;
        end else begin
          rdata_d = lane_load;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe and status are decoded straight from the state register.
  always_comb begin
    done      = (state_q == DONE);
    err       = (state_q == DONE) && err_q;
    busy      = (state_q != IDLE);
    mem_wr    = (state_q == WR);
    vec_hit   = vec_q;
    rdata     = rdata_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl at read latencies 1 and 3.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    int          sel;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    logic        vec;
    int          done_cyc;
    int          wr_cyc;
    logic [31:0] wr_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a [2];
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata_w     [2];
  logic [31:0] mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] mem_rdata_w [2];
  logic        done_w      [2];
  logic        err_w       [2];
  logic        busy_w      [2];
  logic        vec_w       [2];
  logic        mem_wr_w    [2];

  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;

  int unsigned cyc = 0;
  int unsigned t0;
  int          wr_seen;
  int          wr_cyc_seen;
  logic [31:0] wr_data_seen;
  logic [31:0] cur_rdata [2];
  exp_t        sb_q [$];
  exp_t        mon_e;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    logic [31:0] pipe [Lat];

    mem_access_ctrl #(
      .MEM_LATENCY (Lat),
      .VEC_BASE    (32'd253)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start_a[g]),
      .wr        (wr),
      .size      (size),
      .sign_ext  (sign_ext),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata_w[g]),
      .done      (done_w[g]),
      .err       (err_w[g]),
      .busy      (busy_w[g]),
      .vec_hit   (vec_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wr    (mem_wr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );

    // Synchronous memory read port with Lat cycles of address-to-data delay.
    always @(posedge clk) begin
      pipe[0] <= mem_addr_w[g];
      for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata_w[g] = mem[pipe[Lat-1][7:2]];
  end

  // Memory write port: bench preload plus both DUT write strobes.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    for (int g = 0; g < 2; g++) begin
      if (mem_wr_w[g]) mem[mem_addr_w[g][7:2]] <= mem_wdata_w[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: count write pulses, and pop/compare the scoreboard on each done.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (err_w[g] && !done_w[g]) check("err_without_done", 32'(err_w[g]), 32'd0);
      if (mem_wr_w[g]) begin
        wr_seen++;
        wr_cyc_seen  = int'(cyc - t0) + 1;
        wr_data_seen = mem_wdata_w[g];
      end
      if (done_w[g]) begin
        if (sb_q.size() == 0) begin
          check("done_when_idle", 32'(done_w[g]), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_sel", 32'(g), 32'(mon_e.sel));
          check("done_cycle", 32'(int'(cyc - t0) + 1), 32'(mon_e.done_cyc));
          check("err", 32'(err_w[g]), 32'(mon_e.err));
          check("vec_hit", 32'(vec_w[g]), 32'(mon_e.vec));
          if (mon_e.chk_rdata) check("rdata", rdata_w[g], mon_e.rdata);
          check("wr_pulses", 32'(wr_seen), (mon_e.wr_cyc != 0) ? 32'd1 : 32'd0);
          if (mon_e.wr_cyc != 0) begin
            check("wr_cycle", 32'(wr_cyc_seen), 32'(mon_e.wr_cyc));
            check("mem_wdata", wr_data_seen, mon_e.wr_data);
          end
        end
      end
    end
  end

  task automatic wmem(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a[7:2];
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic chk_idle(input int sel, input string pfx);
    check({pfx, "_rdata"}, rdata_w[sel], 32'd0);
    check({pfx, "_done"}, 32'(done_w[sel]), 32'd0);
    check({pfx, "_err"}, 32'(err_w[sel]), 32'd0);
    check({pfx, "_busy"}, 32'(busy_w[sel]), 32'd0);
    check({pfx, "_vec"}, 32'(vec_w[sel]), 32'd0);
    check({pfx, "_mem_addr"}, mem_addr_w[sel], 32'd0);
    check({pfx, "_mem_wr"}, 32'(mem_wr_w[sel]), 32'd0);
    check({pfx, "_mem_wdata"}, mem_wdata_w[sel], 32'd0);
  endtask

  // Predict the outcome from the memory image, push it, then drive the request.
  task automatic run_op(input int sel, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit poke);
    exp_t        e;
    logic [31:0] word, lane, mask;
    int          lat, sh, rel;
    lat         = (sel == 0) ? 1 : 3;
    word        = mem[a[7:2]];
    sh          = 8 * int'(a[1:0]);
    e.sel       = sel;
    e.vec       = (a >= 32'd253) && (a <= 32'd255);
    e.err       = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.chk_rdata = 1'b0;
    e.rdata     = '0;
    e.wr_cyc    = 0;
    e.wr_data   = '0;
    if (e.err) begin
      e.done_cyc  = 1;
      e.chk_rdata = 1'b1;
      e.rdata     = cur_rdata[sel];
    end else if (!w) begin
      lane = word >> sh;
      if (sz == 2'b00) lane = (sx && lane[7]) ? (lane | 32'hFFFF_FF00) : (lane & 32'h0000_00FF);
      else if (sz == 2'b01) lane = (sx && lane[15]) ? (lane | 32'hFFFF_0000) : (lane & 32'h0000_FFFF);
      e.rdata        = lane;
      e.chk_rdata    = 1'b1;
      e.done_cyc     = lat + 2;
      cur_rdata[sel] = lane;
    end else if (sz == 2'b10) begin
      e.wr_cyc   = 1;
      e.wr_data  = wd;
      e.done_cyc = 2;
    end else begin
      mask       = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      e.wr_data  = (word & ~mask) | ((wd << sh) & mask);
      e.wr_cyc   = lat + 2;
      e.done_cyc = lat + 3;
    end
    sb_q.push_back(e);

    @(negedge clk);
    wr = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    wr_seen      = 0;
    start_a[sel] = 1'b1;
    @(posedge clk);
    #1;
    t0           = cyc;
    start_a[sel] = 1'b0;
    if (!e.err) check("mem_addr", mem_addr_w[sel], {a[31:2], 2'b00});
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) begin
      @(posedge clk);
      #2;
      rel = int'(cyc - t0) + 1;
      if (poke) begin
        // A word load elsewhere: if it were accepted it would add a done.
        start_a[sel] = (rel >= 2 && rel <= 4);
        addr = 32'h40; wr = 1'b0; size = 2'b10;
      end
    end
    start_a[sel] = 1'b0;
    if (sb_q.size() != 0) begin
      check("timeout_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start_a[0] = 1'b0; start_a[1] = 1'b0;
    wr = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    t0 = 0; wr_seen = 0; wr_cyc_seen = 0; wr_data_seen = '0;
    cur_rdata[0] = '0; cur_rdata[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");

    // Word load, L=1.
    wmem(32'h10, 32'hDEAD_BEEF);
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

    // Exception-vector byte loads and halfword loads.
    wmem(32'd252, 32'h1122_8344);
    run_op(0, 1'b0, 2'b00, 1'b1, VEC_D, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b00, 1'b0, VEC_D, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b00, 1'b1, VEC_E, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b00, 1'b1, VEC_F, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b00, 1'b1, 32'd252, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);

    // Byte store via read-modify-write, then read it back.
    wmem(32'h20, 32'h1234_5678);
    run_op(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AB, 1'b0);
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    // Misaligned and illegal-size requests.
    run_op(0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h0000_FFFF, 1'b0);
    run_op(0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0);

    // Word store and a byte read of its top lane.
    run_op(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 1'b0);
    run_op(0, 1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 1'b0);

    // Halfword store at L=3 with start pulsed while busy.
    wmem(32'h20, 32'h0000_0000);
    run_op(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 1'b1);
    run_op(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    // Reset during the read phase of a byte store.
    wmem(32'h20, 32'h5566_7788);
    @(negedge clk);
    wr = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h21; wdata = 32'h0000_00AB;
    wr_seen    = 0;
    start_a[0] = 1'b1;
    @(posedge clk);
    #1;
    t0         = cyc;
    start_a[0] = 1'b0;
    check("rd_busy", 32'(busy_w[0]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle(0, "rdrst");
    repeat (3) @(posedge clk);
    #1;
    check("rdrst_wr_pulses", 32'(wr_seen), 32'd0);
    check("rdrst_mem_word", mem[8], 32'h5566_7788);
    cur_rdata[0] = '0;
    cur_rdata[1] = '0;
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
